// File: rtl/gpio_config_loader.sv
// Per-pad GPIO configuration loader: applies tie-cell defaults after reset, then accepts
// daisy-chained serial reconfiguration. Optional GPIO_CFG_READBACK_EN adds capture_strobe readback.
module gpio_config_loader #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_defaults,
  input  logic             serial_data_in,
  input  logic             shift_strobe,
  input  logic             load_strobe,
  input  logic             restore_strobe,
`ifdef GPIO_CFG_READBACK_EN
  input  logic             capture_strobe,
`endif
  output logic             serial_data_out,
  output logic [WIDTH-1:0] gpio_config,
  output logic             config_valid,
  output logic             busy,
  output logic             load_error
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // A word is complete at exactly WIDTH bits; WIDTH+1 marks an overrun and holds there.
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] OVR_CNT  = CNT_W'(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   gpio_config_q, gpio_config_d;
  logic               config_valid_q, config_valid_d;
  logic               load_error_q, load_error_d;
  logic               busy_q, busy_d;
  logic               sdo_q, sdo_d;

  logic [WIDTH-1:0]   eff_word;
  logic [CNT_W-1:0]   eff_cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    shift_reg_d    = shift_reg_q;
    bit_cnt_d      = bit_cnt_q;
    gpio_config_d  = gpio_config_q;
    config_valid_d = config_valid_q;
    load_error_d   = load_error_q;
    eff_word       = shift_reg_q;
    eff_cnt        = bit_cnt_q;

    unique case (state_q)
      ST_INIT: begin
        gpio_config_d  = gpio_defaults;
        config_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end

      ST_IDLE, ST_SHIFT: begin
        // Same-cycle shift is folded into eff_* so a coincident load commits that bit too.
        if (shift_strobe) begin
          eff_word = {shift_reg_q[WIDTH-2:0], serial_data_in};
          if (state_q == ST_IDLE) begin
            eff_cnt = CNT_W'(1);
          end else if (bit_cnt_q == OVR_CNT) begin
            eff_cnt = OVR_CNT;
          end else begin
            eff_cnt = bit_cnt_q + CNT_W'(1);
          end
          shift_reg_d = eff_word;
          bit_cnt_d   = eff_cnt;
          state_d     = ST_SHIFT;
        end

        if (load_strobe) begin
          if (eff_cnt == FULL_CNT) begin
            gpio_config_d = eff_word;
          end else begin
            load_error_d = 1'b1;
          end
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end

`ifdef GPIO_CFG_READBACK_EN
        // Readback capture only when idle and no shift/load competes for shift_reg.
        if (capture_strobe && (state_q == ST_IDLE) && !shift_strobe && !load_strobe) begin
          shift_reg_d = gpio_config_q;
          bit_cnt_d   = '0;
        end
`endif

        if (restore_strobe) begin
          gpio_config_d = gpio_defaults;
          shift_reg_d   = '0;
          bit_cnt_d     = '0;
          load_error_d  = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    sdo_d  = shift_reg_q[WIDTH-1];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_INIT;
      shift_reg_q    <= '0;
      bit_cnt_q      <= '0;
      gpio_config_q  <= '0;
      config_valid_q <= 1'b0;
      load_error_q   <= 1'b0;
      busy_q         <= 1'b0;
      sdo_q          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q        <= state_d;
      shift_reg_q    <= shift_reg_d;
      bit_cnt_q      <= bit_cnt_d;
      gpio_config_q  <= gpio_config_d;
      config_valid_q <= config_valid_d;
      load_error_q   <= load_error_d;
      busy_q         <= busy_d;
      sdo_q          <= sdo_d;
    end
  end

  assign serial_data_out = sdo_q;
  assign gpio_config     = gpio_config_q;
  assign config_valid    = config_valid_q;
  assign busy            = busy_q;
  assign load_error      = load_error_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed self-checking bench for gpio_config_loader; hand-computed expectations.
// Exercises the GPIO_CFG_READBACK_EN path when that macro is defined.
module tb_gpio_config_loader;

  localparam int WIDTH = 10;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] gpio_defaults;
  logic             serial_data_in;
  logic             shift_strobe;
  logic             load_strobe;
  logic             restore_strobe;
`ifdef GPIO_CFG_READBACK_EN
  logic             capture_strobe;
`endif
  logic             serial_data_out;
  logic [WIDTH-1:0] gpio_config;
  logic             config_valid;
  logic             busy;
  logic             load_error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  gpio_config_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .gpio_defaults   (gpio_defaults),
    .serial_data_in  (serial_data_in),
    .shift_strobe    (shift_strobe),
    .load_strobe     (load_strobe),
    .restore_strobe  (restore_strobe),
`ifdef GPIO_CFG_READBACK_EN
    .capture_strobe  (capture_strobe),
`endif
    .serial_data_out (serial_data_out),
    .gpio_config     (gpio_config),
    .config_valid    (config_valid),
    .busy            (busy),
    .load_error      (load_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_data_in = val[i];
      shift_strobe   = 1'b1;
      tick();
    end
    shift_strobe   = 1'b0;
    serial_data_in = 1'b0;
  endtask

  task automatic pulse_load();
    load_strobe = 1'b1;
    tick();
    load_strobe = 1'b0;
  endtask

  task automatic pulse_restore();
    restore_strobe = 1'b1;
    tick();
    restore_strobe = 1'b0;
  endtask

  initial begin
    resetn         = 1'b0;
    gpio_defaults  = 10'h087;
    serial_data_in = 1'b0;
    shift_strobe   = 1'b0;
    load_strobe    = 1'b0;
    restore_strobe = 1'b0;
`ifdef GPIO_CFG_READBACK_EN
    capture_strobe = 1'b0;
`endif

    // Reset state
    #13;
    check("rst_config", 32'(gpio_config), 32'h000);
    check("rst_valid", 32'(config_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(load_error), 32'h0);
    check("rst_sdo", 32'(serial_data_out), 32'h0);
    #10 resetn = 1'b1;   // t=23, edge at 25 is the INIT edge
    #1;
    check("pre_init_valid", 32'(config_valid), 32'h0);
    tick();
    check("init_config", 32'(gpio_config), 32'h087);
    check("init_valid", 32'(config_valid), 32'h1);

    // Full 10-bit word 2A5
    shift_bits(16'h02A5, 1);
    check("shift_busy", 32'(busy), 32'h1);
    shift_bits(16'h00A5, 9);
    check("shift_busy_full", 32'(busy), 32'h1);
    pulse_load();
    check("load_2a5", 32'(gpio_config), 32'h2A5);
    check("load_2a5_err", 32'(load_error), 32'h0);
    check("load_2a5_busy", 32'(busy), 32'h0);

    // Short word: 7 bits -> error, no commit
    pulse_restore();
    check("restore_config", 32'(gpio_config), 32'h087);
    shift_bits(16'h007F, 7);
    pulse_load();
    check("short_config", 32'(gpio_config), 32'h087);
    check("short_err", 32'(load_error), 32'h1);
    check("short_valid", 32'(config_valid), 32'h1);
    pulse_restore();
    check("restore_clr_err", 32'(load_error), 32'h0);

    // 9 bits, then 10th bit with simultaneous load -> commit 1C3
    shift_bits(16'h01C3 >> 1, 9);
    serial_data_in = 1'b1;
    shift_strobe   = 1'b1;
    load_strobe    = 1'b1;
    tick();
    shift_strobe   = 1'b0;
    load_strobe    = 1'b0;
    serial_data_in = 1'b0;
    check("shiftload_config", 32'(gpio_config), 32'h1C3);
    check("shiftload_err", 32'(load_error), 32'h0);
    check("shiftload_busy", 32'(busy), 32'h0);

    // Overrun: 12 bits -> error, no commit
    shift_bits(16'h0FFF, 12);
    check("overrun_busy", 32'(busy), 32'h1);
    pulse_load();
    check("overrun_config", 32'(gpio_config), 32'h1C3);
    check("overrun_err", 32'(load_error), 32'h1);

    // Restore beats a coincident load of a valid word
    pulse_restore();
    check("restore2_err", 32'(load_error), 32'h0);
    tick();
    check("sdo_cleared", 32'(serial_data_out), 32'h0);
    shift_bits(16'h03FF, 10);
    check("sdo_lag", 32'(serial_data_out), 32'h0);
    restore_strobe = 1'b1;
    load_strobe    = 1'b1;
    tick();
    restore_strobe = 1'b0;
    load_strobe    = 1'b0;
    check("restore_load_config", 32'(gpio_config), 32'h087);
    check("restore_load_busy", 32'(busy), 32'h0);
    check("sdo_msb", 32'(serial_data_out), 32'h1);
    tick();
    check("sdo_after_restore", 32'(serial_data_out), 32'h0);

    // Reset asserted mid-shift clears outputs asynchronously
    shift_bits(16'h000F, 4);
    check("mid_busy", 32'(busy), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async_config", 32'(gpio_config), 32'h000);
    check("async_valid", 32'(config_valid), 32'h0);
    check("async_busy", 32'(busy), 32'h0);

    // Strobes are ignored in INIT; load with zero bits in IDLE flags an error
    gpio_defaults = 10'h087;
    load_strobe   = 1'b1;
    #3 resetn = 1'b1;
    tick();
    check("init2_config", 32'(gpio_config), 32'h087);
    check("init2_err", 32'(load_error), 32'h0);
    tick();
    load_strobe = 1'b0;
    check("empty_load_err", 32'(load_error), 32'h1);
    check("empty_load_config", 32'(gpio_config), 32'h087);

`ifdef GPIO_CFG_READBACK_EN
    // Readback: capture active config then shift it out MSB-first
    begin
      logic [WIDTH-1:0] exp_bits;
      exp_bits = 10'h087;
      pulse_restore();
      capture_strobe = 1'b1;
      tick();
      capture_strobe = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        serial_data_in = 1'b0;
        shift_strobe   = 1'b1;
        tick();
        check($sformatf("readback_bit%0d", i), 32'(serial_data_out), 32'(exp_bits[i]));
      end
      shift_strobe = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpio_config_loader.md
Name: gpio_config_loader

Overview:
- Consumer end of the per-pad GPIO defaults path. Takes the 10-bit constant `gpio_defaults` word from a defaults block and loads it as the pad's active configuration after reset.
- Afterwards accepts serial reconfiguration: a daisy-chained shift register with commit on a load strobe, plus on-demand restore of defaults.
- Sits between the defaults block and the pad control logic, one instance per user GPIO.

Parameters:
- WIDTH, 10, configuration word width; must match `gpio_defaults` width.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clock  input  1  block clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- gpio_defaults  input  WIDTH  constant default config from the tie-cell defaults block.
- serial_data_in  input  1  serial config bit, sampled when `shift_strobe`=1.
- shift_strobe  input  1  single-cycle pulse; shift one bit in.
- load_strobe  input  1  single-cycle pulse; commit the shifted word.
- restore_strobe  input  1  single-cycle pulse; reload `gpio_defaults` into the active config.
- serial_data_out  output  1  registered MSB of the shift register (daisy chain to next pad).
- gpio_config  output  WIDTH  active pad configuration.
- config_valid  output  1  high once defaults or a committed word are in `gpio_config`.
- busy  output  1  high while a serial word is partially shifted (state SHIFT).
- load_error  output  1  sticky: a load occurred with bit count != WIDTH.

Behaviour:
- Reset (`resetn`=0, async), all outputs and registers clear:
  - `gpio_config`=0, `config_valid`=0, `busy`=0, `load_error`=0, `serial_data_out`=0.
  - shift_reg=0, bit_cnt=0, state=INIT.
- INIT:
  - First rising edge after `resetn` deasserts: `gpio_config`<=`gpio_defaults`, `config_valid`<=1, state->IDLE. Load latency is 1 cycle.
  - All strobes are ignored in INIT.
- IDLE:
  - `shift_strobe` -> shift_reg<={shift_reg[WIDTH-2:0],serial_data_in}; bit_cnt<=1; state->SHIFT.
- SHIFT, on `shift_strobe`:
  - shift as above.
  - bit_cnt<=bit_cnt+1, saturating at WIDTH+1 (overrun marker).
- `load_strobe` in IDLE or SHIFT:
  - Let eff_word/eff_cnt be shift_reg/bit_cnt after applying any same-cycle shift. Simultaneous shift+load therefore commits the word including that bit.
  - If eff_cnt==WIDTH: `gpio_config`<=eff_word.
  - Otherwise: no commit, and `load_error`<=1.
  - In both cases bit_cnt<=0, state->IDLE. shift_reg retains its contents.
- `restore_strobe`:
  - Highest priority among strobes; any same-cycle shift/load is discarded.
  - `gpio_config`<=`gpio_defaults`, bit_cnt<=0, shift_reg<=0, `load_error`<=0, state->IDLE.
- Output timing:
  - `busy` = (state==SHIFT), registered.
  - `serial_data_out` is registered and equals shift_reg[WIDTH-1] one cycle after each update.
- `config_valid` never drops after INIT except on reset.
- Reset asserted mid-shift aborts immediately. Partial words are never committed.
- Strobes held high multiple cycles act once per cycle; no edge detection.

Optional Feature:
- Macro: GPIO_CFG_READBACK_EN.
- Defined:
  - adds input `capture_strobe` (1 bit).
  - In IDLE only: shift_reg<=`gpio_config`, bit_cnt<=0. Enables shifting the active config out on `serial_data_out`.
  - Ignored in SHIFT/INIT. `restore_strobe` has priority over it.
- Undefined: port absent; shift_reg loads only from `serial_data_in`.

Test Plan:
- Reset, then release with `gpio_defaults`=10'h087 -> cycle 1 after release: `gpio_config`=10'h087, `config_valid`=1; both 0 during reset.
- Shift 10 bits MSB-first encoding 10'h2A5, then pulse `load_strobe` -> `gpio_config`=10'h2A5, `load_error`=0, `busy` goes 1→0.
- Shift 7 bits then load -> `gpio_config` unchanged (10'h087), `load_error`=1. `restore_strobe` clears it to 0.
- Shift 9 bits, then assert shift+load in the same cycle with 10th bit -> commit of the full 10-bit word. Separately, shift 12 bits then load -> overrun, `load_error`=1, no commit.
- After loading 10'h2A5: `restore_strobe` coincident with `load_strobe` -> `gpio_config`=10'h087. Assert `resetn`=0 mid-shift -> all outputs 0 immediately.
- (GPIO_CFG_READBACK_EN) Active config 10'h087, pulse `capture_strobe`, then 10 shift strobes -> `serial_data_out` sequence 0,0,1,0,0,0,0,1,1,1.
